sequence_player: RTL and testbench
==================================

// Module: sequence_player
// PURPOSE
//  Consumes the five 6-bit sequence values from the random-number splitter and plays
//  the first `level` of them to the Simon display/LED driver, one at a time.
//  Each value is shown for ON_CYCLES clocks, followed by a blank gap of OFF_CYCLES clocks.
//  Sits between the number splitter and the display decoder; the game FSM drives it
//  with a start/done handshake.
// PARAMETERS
//  ON_CYCLES   25_000_000  clocks each value is shown (>=1)
//  OFF_CYCLES  12_500_000  blank clocks after each value (>=1)
//  TIMER_W     25          phase timer width; must hold max(ON_CYCLES,OFF_CYCLES)-1
// PORTS
//  clk         in   1  system clock; one clock domain, all logic on its rising edge
//  reset       in   1  synchronous, active-high
//  start       in   1  one-cycle request to play; sampled only in IDLE
//  abort       in   1  stop playback and return to IDLE; no done pulse
//  level       in   3  number of values to play; 0 = none, values >5 clamp to 5
//  num0..num4  in   6  each: sequence values, num0 plays first
//  show_valid  out  1  high while a value is being shown
//  show_num    out  6  value being shown; 0 when show_valid=0
//  show_idx    out  3  index (0..4) of the value being shown; 0 when show_valid=0
//  busy        out  1  high from the cycle after start is accepted through the done cycle
//  done        out  1  one-cycle pulse when playback completes
// BEHAVIOUR
//  - Reset: state=IDLE; timer=0; idx=0; every output is 0. Reset mid-playback aborts immediately.
//  - States: IDLE, SHOW, GAP, DONE.
//  - IDLE, start=1, abort=0:
//    - snapshot num0..num4 and clamped level into internal registers;
//    - later input changes have no effect until the next start.
//    - If clamped level=0: go to DONE.
//    - Otherwise: go to SHOW with idx=0 and timer=0.
//  - SHOW:
//    - show_valid=1, show_num=snap[idx], show_idx=idx.
//    - Stays exactly ON_CYCLES cycles, then goes to GAP with timer=0.
//  - GAP:
//    - outputs blank.
//    - Stays exactly OFF_CYCLES cycles.
//    - Then, if idx==L-1: go to DONE. Otherwise: idx+1 and go to SHOW.
//  - DONE: done=1 and busy=1 for one cycle, then IDLE.
//  - Timing: start is sampled at edge k.
//    - Value i is visible in cycles k+1+i*(ON+OFF) .. k+ON+i*(ON+OFF).
//    - done is high in cycle k+1+L*(ON+OFF).
//    - For L=0, done is high in cycle k+1.
//  - start in any state other than IDLE: ignored and not queued.
//    - start in the same cycle that DONE returns to IDLE is ignored; the next start must come in IDLE.
//  - abort:
//    - In SHOW, GAP or DONE: next cycle is IDLE with all outputs 0 and no done pulse.
//    - In IDLE: no effect, and it beats a simultaneous start (start is dropped).
//  - Timer counts 0..N-1 and wraps to 0 on each phase change.
//  - idx is 3 bits and never exceeds 4.
//  - All outputs are registered.
// STRUCTURE
//  - simon_pkg:
//    - NUM_W=6, SEQ_LEN=5, IDX_W=3 constants;
//    - player_state_t enum {IDLE,SHOW,GAP,DONE};
//    - clamp_level() function.
//  - One sub-module, phase_timer (TIMER_W):
//    - inputs: clear, en;
//    - output: last, which is high when count == limit-1;
//    - input: limit, selected by the FSM as ON_CYCLES or OFF_CYCLES.
// TESTING
//  (ON_CYCLES=3, OFF_CYCLES=2)
//  1. reset, then level=3, nums=5,17,42,63,1, start at edge k
//     -> show_num 5,17,42 in cycles k+1..3, k+6..8, k+11..13;
//     -> gaps blank; done only in cycle k+16; busy k+1..k+16.
//  2. level=0 start -> done in k+1, show_valid never high; level=7
//     -> plays all 5 values, done in k+26.
//  3. change num0..num4 and level during playback
//     -> shown values and length match the snapshot at start.
//  4. abort in the 2nd GAP cycle of value 1 -> IDLE next cycle, outputs 0, no done;
//     a following start replays from num0.
//  5. start held high through playback -> one playback only;
//     start and abort together in IDLE -> stays IDLE.
//  6. reset asserted during SHOW -> next cycle all outputs 0, IDLE;
//     a fresh start behaves as in test 1.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared constants, state encoding and level clamping for the Simon sequence player.
`default_nettype none

package simon_pkg;

    localparam int NUM_W   = 6;
    localparam int SEQ_LEN = 5;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } player_state_t;

    // Requests longer than the stored sequence play the whole sequence.
    function automatic logic [IDX_W-1:0] clamp_level(input logic [IDX_W-1:0] lvl);
        return (lvl > IDX_W'(SEQ_LEN)) ? IDX_W'(SEQ_LEN) : lvl;
    endfunction

endpackage

`default_nettype wire

// File: rtl/phase_timer.sv
// Phase counter for the sequence player; flags the final cycle of a phase of 'limit' cycles.
`default_nettype none

module phase_timer #(
    parameter int TIMER_W = 25
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               en,
    input  logic [TIMER_W-1:0] limit,
    output logic               last
);

    logic [TIMER_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + TIMER_W'(1);
        end
    end

    assign last = (count_q == (limit - TIMER_W'(1)));

endmodule

`default_nettype wire

// File: rtl/sequence_player.sv
// Plays the first 'level' snapshotted sequence values, each shown ON_CYCLES then blanked OFF_CYCLES.
`default_nettype none

module sequence_player
    import simon_pkg::*;
#(
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 12_500_000,
    parameter int TIMER_W    = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [IDX_W-1:0] level,
    input  logic [NUM_W-1:0] num0,
    input  logic [NUM_W-1:0] num1,
    input  logic [NUM_W-1:0] num2,
    input  logic [NUM_W-1:0] num3,
    input  logic [NUM_W-1:0] num4,
    output logic             show_valid,
    output logic [NUM_W-1:0] show_num,
    output logic [IDX_W-1:0] show_idx,
    output logic             busy,
    output logic             done
);

    player_state_t                  state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [IDX_W-1:0]               len_q, len_d;
    logic [SEQ_LEN-1:0][NUM_W-1:0]  snap_q, snap_d;

    logic                           show_valid_q, show_valid_d;
    logic [NUM_W-1:0]               show_num_q, show_num_d;
    logic [IDX_W-1:0]               show_idx_q, show_idx_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;

    logic                           timer_last;
    logic                           timer_clear;
    logic                           timer_en;
    logic [TIMER_W-1:0]             timer_limit;
    logic [IDX_W-1:0]               level_clamped;

    assign level_clamped = clamp_level(level);

    // Every state change starts a fresh phase, so the count always begins at 0.
    assign timer_clear = (state_d != state_q);
    assign timer_en    = (state_q == SHOW) || (state_q == GAP);
    assign timer_limit = (state_q == GAP) ? TIMER_W'(OFF_CYCLES) : TIMER_W'(ON_CYCLES);

    phase_timer #(
        .TIMER_W (TIMER_W)
    ) u_phase_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clear),
        .en    (timer_en),
        .limit (timer_limit),
        .last  (timer_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            len_q        <= '0;
            snap_q       <= '0;
            show_valid_q <= 1'b0;
            show_num_q   <= '0;
            show_idx_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            snap_q       <= snap_d;
            show_valid_q <= show_valid_d;
            show_num_q   <= show_num_d;
            show_idx_q   <= show_idx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        snap_d  = snap_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    snap_d  = {num4, num3, num2, num1, num0};
                    len_d   = level_clamped;
                    idx_d   = '0;
                    state_d = (level_clamped == '0) ? DONE : SHOW;
                end
            end
            SHOW: begin
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (timer_last) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (timer_last) begin
                    if (idx_q == (len_q - IDX_W'(1))) begin
                        state_d = DONE;
                        idx_d   = '0;
                    end else begin
                        state_d = SHOW;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        show_valid_d = (state_d == SHOW);
        show_num_d   = show_valid_d ? snap_d[idx_d] : '0;
        show_idx_d   = show_valid_d ? idx_d : '0;
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
    end

    assign show_valid = show_valid_q;
    assign show_num   = show_num_q;
    assign show_idx   = show_idx_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_sequence_player.sv
// Directed self-checking bench for sequence_player with short show/gap phases.
`default_nettype none

module tb_sequence_player;

    localparam int ON  = 3;
    localparam int OFF = 2;
    localparam int PER = ON + OFF;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [2:0] level;
    logic [5:0] num0, num1, num2, num3, num4;
    logic       show_valid;
    logic [5:0] show_num;
    logic [2:0] show_idx;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    sequence_player #(
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF),
        .TIMER_W    (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .level      (level),
        .num0       (num0),
        .num1       (num1),
        .num2       (num2),
        .num3       (num3),
        .num4       (num4),
        .show_valid (show_valid),
        .show_num   (show_num),
        .show_idx   (show_idx),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " show_valid"}, 32'(show_valid), 0);
        check({tag, " show_num"},   32'(show_num),   0);
        check({tag, " show_idx"},   32'(show_idx),   0);
        check({tag, " busy"},       32'(busy),       0);
        check({tag, " done"},       32'(done),       0);
    endtask

    task automatic set_inputs(input logic [2:0] lv, input logic [5:0] a, b, c, d, e);
        level = lv; num0 = a; num1 = b; num2 = c; num3 = d; num4 = e;
    endtask

    // Start one playback and check every cycle from k+1 to two cycles past done.
    task automatic run_play(input string tag, input int L, input logic [5:0] exp_n [5],
                            input bit hold_start, input bit mutate);
        int ph, i;
        bit showing;
        start = 1'b1;
        for (int c = 1; c <= L * PER + 3; c++) begin
            tick();
            if (c == 1 && !hold_start) start = 1'b0;
            if (hold_start && c == L * PER + 2) start = 1'b0;
            if (mutate && c == 2) set_inputs(3'd1, 6'd9, 6'd9, 6'd9, 6'd9, 6'd9);
            ph = (c - 1) % PER;
            i  = (c - 1) / PER;
            showing = (i < L) && (ph < ON);
            check($sformatf("%s c%0d valid", tag, c), 32'(show_valid), 32'(showing));
            check($sformatf("%s c%0d num", tag, c), 32'(show_num), showing ? 32'(exp_n[i]) : 0);
            check($sformatf("%s c%0d idx", tag, c), 32'(show_idx), showing ? 32'(i) : 0);
            check($sformatf("%s c%0d done", tag, c), 32'(done), 32'(c == L * PER + 1));
            check($sformatf("%s c%0d busy", tag, c), 32'(busy), 32'(c <= L * PER + 1));
        end
        start = 1'b0;
    endtask

    logic [5:0] seq_a [5];
    logic [5:0] seq_b [5];

    initial begin
        seq_a = '{6'd5, 6'd17, 6'd42, 6'd63, 6'd1};
        seq_b = '{6'd11, 6'd22, 6'd33, 6'd44, 6'd55};
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        set_inputs(3'd3, 6'd5, 6'd17, 6'd42, 6'd63, 6'd1);
        tick();
        tick();
        check_idle("reset");
        reset = 1'b0;
        tick();
        check_idle("post-reset");

        // Three values, then level 0, then an over-range level.
        run_play("t1", 3, seq_a, 1'b0, 1'b0);
        set_inputs(3'd0, 6'd5, 6'd17, 6'd42, 6'd63, 6'd1);
        run_play("t2a", 0, seq_a, 1'b0, 1'b0);
        set_inputs(3'd7, 6'd11, 6'd22, 6'd33, 6'd44, 6'd55);
        run_play("t2b", 5, seq_b, 1'b0, 1'b0);

        // Inputs change mid-playback; snapshot must hold.
        set_inputs(3'd3, 6'd5, 6'd17, 6'd42, 6'd63, 6'd1);
        run_play("t3", 3, seq_a, 1'b0, 1'b1);

        // Abort in the second gap cycle after value index 1.
        set_inputs(3'd3, 6'd5, 6'd17, 6'd42, 6'd63, 6'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 10; c++) tick();
        check("t4 gap valid", 32'(show_valid), 0);
        check("t4 gap busy", 32'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("t4 abort");
        for (int c = 0; c < 8; c++) begin
            tick();
            check($sformatf("t4 after c%0d done", c), 32'(done), 0);
            check($sformatf("t4 after c%0d busy", c), 32'(busy), 0);
        end
        run_play("t4 replay", 3, seq_a, 1'b0, 1'b0);

        // Start held through a whole playback; then start+abort together in IDLE.
        set_inputs(3'd1, 6'd5, 6'd17, 6'd42, 6'd63, 6'd1);
        run_play("t5a", 1, seq_a, 1'b1, 1'b0);
        tick();
        check_idle("t5a settle");
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_idle("t5b");
        tick();
        check_idle("t5b next");

        // Reset during SHOW, then a fresh playback.
        set_inputs(3'd3, 6'd5, 6'd17, 6'd42, 6'd63, 6'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t6 showing", 32'(show_valid), 1);
        check("t6 num", 32'(show_num), 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("t6 reset");
        tick();
        check_idle("t6 idle");
        run_play("t6 fresh", 3, seq_a, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
